// File: rtl/prime_seq_gen_if.sv
// Valid/ready stream carrying generated primes from prime_seq_gen to its consumer.
interface prime_seq_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Producer side: drives data/valid, observes ready.
  modport master (output out_valid, output out_data, input out_ready);
  // Consumer side: observes data/valid, drives ready.
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/prime_seq_gen.sv
// Ascending prime generator over [2, limit] using sequential trial division.
// One divisor is tried per cycle; each prime is offered on a valid/ready stream.
// Optional feature macro PRIME_GEN_COUNT_EN adds the prime_count output.
module prime_seq_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  prime_seq_gen_if.master  out,
  output logic             busy,
  output logic             done
`ifdef PRIME_GEN_COUNT_EN
  ,
  output logic [WIDTH-1:0] prime_count
`endif
);

  localparam int unsigned SQW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] div;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SQW-1:0]   sq;
  logic [WIDTH-1:0] rem;
  logic             last_cand;
`ifdef PRIME_GEN_COUNT_EN
  logic [WIDTH-1:0] cnt_q;
`endif

  // Trial-division datapath; div is never zero while in TEST/EMIT.
  assign sq        = SQW'(div) * SQW'(div);
  assign rem       = cand % div;
  assign last_cand = (cand == lim);

  assign out.out_valid = valid_q;
  assign out.out_data  = data_q;
`ifdef PRIME_GEN_COUNT_EN
  assign prime_count   = cnt_q;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lim     <= '0;
      cand    <= '0;
      div     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PRIME_GEN_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Abort wins over everything, including a same-cycle handshake.
        state   <= IDLE;
        valid_q <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              lim <= limit;
`ifdef PRIME_GEN_COUNT_EN
              cnt_q <= '0;
`endif
              if (limit < WIDTH'(2)) begin
                state <= DONE;
              end else begin
                cand  <= WIDTH'(2);
                div   <= WIDTH'(2);
                busy  <= 1'b1;
                state <= TEST;
              end
            end
          end
          TEST: begin
            if (sq > SQW'(cand)) begin
              data_q  <= cand;
              valid_q <= 1'b1;
              state   <= EMIT;
            end else if (rem == '0) begin
              if (last_cand) begin
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                cand <= cand + WIDTH'(1);
                div  <= WIDTH'(2);
              end
            end else begin
              div <= div + WIDTH'(1);
            end
          end
          EMIT: begin
            if (out.out_ready) begin
              valid_q <= 1'b0;
`ifdef PRIME_GEN_COUNT_EN
              if (cnt_q != '1) cnt_q <= cnt_q + WIDTH'(1);
`endif
              if (last_cand) begin
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                cand  <= cand + WIDTH'(1);
                div   <= WIDTH'(2);
                state <= TEST;
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
